seqdec_sched: RTL and testbench
===============================

SEQDEC_SCHED -- requirements
Module: seqdec_sched

Interface
REQ-001 SHALL have parameter CNT_W, 8, width of the hit counter.
REQ-002 SHALL have parameter DRAIN_CYC, 2, idle-bit cycles after the last data bit to catch late detector hits (>=1).
REQ-003 Clk  input  1  single clock; all state changes on posedge Clk.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin a run; sampled only in IDLE.
REQ-006 num_bytes  input  8  bytes in the run, latched at start; 0 = empty run.
REQ-007 byte_in  input  8  parallel data byte, shifted MSB-first.
REQ-008 byte_valid  input  1  byte_in valid.
REQ-009 byte_ready  output  1  block accepts byte_in; transfer when byte_valid & byte_ready.
REQ-010 ser_out  output  1  serial bit to the detector's Inp.
REQ-011 ser_valid  output  1  ser_out carries a data bit this cycle.
REQ-012 det_hit  input  1  detector Out.
REQ-013 hit_cnt  output  CNT_W  detections counted in the current or last run.
REQ-014 busy  output  1  state != IDLE.
REQ-015 done  output  1  one-cycle pulse at the end of a run.
REQ-016 overflow  output  1  sticky; hit_cnt saturated in this run.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, SHIFT, DRAIN; internal registers: shreg[7:0], bitcnt[2:0], remaining[7:0], draincnt.
REQ-018 IDLE: start=1 latches remaining<=num_bytes, clears hit_cnt and overflow, and moves to LOAD (num_bytes!=0) or DRAIN (num_bytes==0); start is ignored in all other states.
REQ-019 LOAD: byte_ready=1; on transfer shreg<=byte_in, bitcnt<=7, moves to SHIFT; otherwise waits indefinitely.
REQ-020 SHIFT: ser_out=shreg[7], ser_valid=1; each cycle shreg shifts left by 1 and bitcnt decrements.
REQ-021 A byte accepted in cycle t SHALL appear on ser_out in cycles t+1..t+8, MSB first.
REQ-022 In SHIFT with bitcnt==0, remaining SHALL decrement. If the new remaining is 0, the next state is DRAIN with byte_ready=0. Otherwise byte_ready=1.
REQ-023 For the bitcnt==0 case with bytes remaining, a transfer in that cycle SHALL reload shreg and bitcnt and stay in SHIFT with no gap bit. With no transfer, the next state is LOAD.
REQ-024 In LOAD and DRAIN, ser_out=0 and ser_valid=0. The detector sees zeros during upstream stalls.
REQ-025 DRAIN SHALL last exactly DRAIN_CYC cycles, then go to IDLE with done=1 for the first IDLE cycle only.
REQ-026 Each cycle with det_hit=1 in LOAD, SHIFT or DRAIN SHALL increment hit_cnt. Hits in IDLE are ignored.
REQ-027 hit_cnt SHALL saturate at 2^CNT_W-1. A hit while saturated sets overflow, which holds until the next accepted start or Reset.
REQ-028 hit_cnt and overflow SHALL hold their values in IDLE until the next accepted start.
REQ-029 busy, byte_ready, ser_out, ser_valid and done SHALL be glitch-free functions of registered state.

Reset
REQ-030 Reset=1 at a posedge SHALL force IDLE and clear shreg, bitcnt, remaining, draincnt, hit_cnt, overflow and done from any state, mid-run included.
REQ-031 A reset mid-run SHALL produce no done pulse.
REQ-032 While Reset=1, all outputs SHALL be 0 and start and byte_valid SHALL be ignored.

Verification
REQ-033 Reset: Reset high 2 cycles -> busy=0, byte_ready=0, ser_out=0, ser_valid=0, hit_cnt=0, done=0, overflow=0.
REQ-034 Back-to-back run, bench 0x45 detector model on ser_out/det_hit:
- Stimulus: start, num_bytes=3, bytes 0x26, 0x45, 0x93 with byte_valid held high.
- Response: ser_out shows 24 contiguous bits 0010_0110_0100_0101_1001_0011 with ser_valid=1 throughout.
- Response: done pulses DRAIN_CYC+1 cycles after the last bit, with hit_cnt=1.
REQ-035 Stall: byte_valid low 5 cycles between bytes 1 and 2 -> LOAD for 5 cycles, ser_valid=0, ser_out=0, byte_ready=1, remaining unchanged; the second byte's MSB follows 1 cycle after the transfer.
REQ-036 Empty run: start with num_bytes=0 -> byte_ready never 1, ser_valid never 1, done at cycle DRAIN_CYC+1 after start, hit_cnt=0.
REQ-037 Saturation: CNT_W=2, det_hit high 6 cycles during SHIFT -> hit_cnt=3, overflow=1. A following start clears both to 0.
REQ-038 Reset mid-SHIFT, then start pulsed while busy:
- Reset in byte 2 bit 4 -> IDLE next cycle, no done.
- start pulsed while busy in a fresh run -> no effect on remaining or hit_cnt.

Source files
------------

// File: rtl/seqdec_sched.sv
`default_nettype none
// ============================================================================
// Module  : seqdec_sched
// Purpose : Serialises a run of bytes MSB-first into a sequence detector and
//           counts the detector's hits over the run.
// Rev     : 1.0 - initial release
// ============================================================================
module seqdec_sched #(
    parameter int CNT_W     = 8,
    parameter int DRAIN_CYC = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [7:0]       num_bytes,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             det_hit,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam int                c_dc_w       = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [c_dc_w-1:0] c_drain_last = c_dc_w'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0]  c_cnt_max    = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t              r_state;
    logic [7:0]          r_shreg;
    logic [2:0]          r_bitcnt;
    logic [7:0]          r_remaining;
    logic [c_dc_w-1:0]   r_draincnt;
    logic [CNT_W-1:0]    r_hit_cnt;
    logic                r_overflow;
    logic                r_done;
    logic                r_busy;
    logic                r_byte_ready;
    logic                r_ser_out;
    logic                r_ser_valid;

    // Outputs are registered one cycle ahead: each transition sets the value
    // the outputs must show in the state being entered.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_shreg      <= '0;
            r_bitcnt     <= '0;
            r_remaining  <= '0;
            r_draincnt   <= '0;
            r_hit_cnt    <= '0;
            r_overflow   <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_byte_ready <= 1'b0;
            r_ser_out    <= 1'b0;
            r_ser_valid  <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if ((r_state != ST_IDLE) && det_hit) begin
                if (r_hit_cnt == c_cnt_max) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_hit_cnt <= r_hit_cnt + 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_remaining <= num_bytes;
                        r_hit_cnt   <= '0;
                        r_overflow  <= 1'b0;
                        r_busy      <= 1'b1;
                        if (num_bytes != 8'd0) begin
                            r_state      <= ST_LOAD;
                            r_byte_ready <= 1'b1;
                        end else begin
                            r_state    <= ST_DRAIN;
                            r_draincnt <= c_drain_last;
                        end
                    end
                end

                ST_LOAD: begin
                    if (byte_valid) begin
                        r_shreg      <= byte_in;
                        r_bitcnt     <= 3'd7;
                        r_ser_out    <= byte_in[7];
                        r_ser_valid  <= 1'b1;
                        r_byte_ready <= 1'b0;
                        r_state      <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    r_shreg  <= {r_shreg[6:0], 1'b0};
                    r_bitcnt <= r_bitcnt - 3'd1;
                    if (r_bitcnt != 3'd0) begin
                        r_ser_out    <= r_shreg[6];
                        // Next cycle is the last bit; open the window if more bytes follow.
                        r_byte_ready <= (r_bitcnt == 3'd1) && (r_remaining != 8'd1);
                    end else begin
                        r_remaining <= r_remaining - 8'd1;
                        if (r_remaining == 8'd1) begin
                            r_state      <= ST_DRAIN;
                            r_draincnt   <= c_drain_last;
                            r_ser_out    <= 1'b0;
                            r_ser_valid  <= 1'b0;
                            r_byte_ready <= 1'b0;
                        end else if (byte_valid) begin
                            r_shreg      <= byte_in;
                            r_bitcnt     <= 3'd7;
                            r_ser_out    <= byte_in[7];
                            r_byte_ready <= 1'b0;
                        end else begin
                            r_state      <= ST_LOAD;
                            r_ser_out    <= 1'b0;
                            r_ser_valid  <= 1'b0;
                            r_byte_ready <= 1'b1;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (r_draincnt == '0) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_draincnt <= r_draincnt - 1'b1;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign byte_ready = r_byte_ready;
    assign ser_out    = r_ser_out;
    assign ser_valid  = r_ser_valid;
    assign hit_cnt    = r_hit_cnt;
    assign busy       = r_busy;
    assign done       = r_done;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_seqdec_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_seqdec_sched
// Purpose : Self-checking bench for seqdec_sched (8-bit and 2-bit counters).
// Rev     : 1.0 - initial release
// ============================================================================
module tb_seqdec_sched;

    localparam int DRAIN_CYC = 2;

    logic       Clk = 1'b0;
    logic       Reset, start, byte_valid, det_vec, det_sel;
    logic [7:0] num_bytes, byte_in;
    wire        det_hit;
    wire        byte_ready, ser_out, ser_valid, busy, done, overflow;
    wire [7:0]  hit_cnt;
    wire        s_ready, s_so, s_sv, s_busy, s_done, s_ovf;
    wire [1:0]  s_cnt;

    logic [7:0] hist = '0;
    logic       det_live = 1'b0;

    always #5 Clk = ~Clk;

    seqdec_sched #(.CNT_W(8), .DRAIN_CYC(DRAIN_CYC)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .num_bytes(num_bytes),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .ser_out(ser_out), .ser_valid(ser_valid), .det_hit(det_hit),
        .hit_cnt(hit_cnt), .busy(busy), .done(done), .overflow(overflow)
    );

    seqdec_sched #(.CNT_W(2), .DRAIN_CYC(DRAIN_CYC)) dut_sat (
        .Clk(Clk), .Reset(Reset), .start(start), .num_bytes(num_bytes),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(s_ready),
        .ser_out(s_so), .ser_valid(s_sv), .det_hit(det_hit),
        .hit_cnt(s_cnt), .busy(s_busy), .done(s_done), .overflow(s_ovf)
    );

    // Registered 0x45 pattern detector watching the serial line every cycle.
    always @(posedge Clk) begin
        hist     <= {hist[6:0], ser_out};
        det_live <= ({hist[6:0], ser_out} == 8'h45);
    end
    assign det_hit = det_sel ? det_live : det_vec;

    typedef struct {
        logic       rst, st;
        logic [7:0] nb;
        logic       bv;
        logic [7:0] bin;
        logic       hit;
        logic       eb, er, eso, esv, ed, chk;
        logic [7:0] ecnt8;
        logic       eovf8;
        logic [1:0] ecnt2;
        logic       eovf2;
    } vec_t;

    vec_t q[$];
    vec_t rtab[4];
    int   n_vec = 0, n_bad = 0, vidx = 0;
    int   m_cnt8, m_cnt2;
    logic m_ovf8, m_ovf2;

    function automatic vec_t mkv(input logic rst, st, input logic [7:0] nb, input logic bv,
                                 input logic [7:0] bin, input logic hit,
                                 input logic eb, er, eso, esv, ed, chk);
        vec_t v;
        v.rst = rst; v.st = st; v.nb = nb; v.bv = bv; v.bin = bin; v.hit = hit;
        v.eb = eb; v.er = er; v.eso = eso; v.esv = esv; v.ed = ed; v.chk = chk;
        v.ecnt8 = '0; v.eovf8 = 1'b0; v.ecnt2 = '0; v.eovf2 = 1'b0;
        return v;
    endfunction

    function automatic logic rb();
        return ($urandom_range(1) != 0);
    endfunction

    function automatic logic [7:0] r8();
        return 8'($urandom);
    endfunction

    function automatic logic hb(input int hmode);
        return (hmode == 1) ? ($urandom_range(2) == 0) : 1'b0;
    endfunction

    // Queue one cycle and advance the reference hit counters by that cycle's rules.
    task automatic push(input logic rst, st, input logic [7:0] nb, input logic bv,
                        input logic [7:0] bin, input logic hit,
                        input logic eb, er, eso, esv, ed, chk, acc);
        vec_t v;
        v = mkv(rst, st, nb, bv, bin, hit, eb, er, eso, esv, ed, chk);
        v.ecnt8 = 8'(m_cnt8); v.eovf8 = m_ovf8;
        v.ecnt2 = 2'(m_cnt2); v.eovf2 = m_ovf2;
        q.push_back(v);
        if (rst || acc) begin
            m_cnt8 = 0; m_ovf8 = 1'b0; m_cnt2 = 0; m_ovf2 = 1'b0;
        end else if (eb && hit) begin
            if (m_cnt8 == 255) m_ovf8 = 1'b1; else m_cnt8++;
            if (m_cnt2 == 3)   m_ovf2 = 1'b1; else m_cnt2++;
        end
    endtask

    function automatic logic sb(input int sprob);
        return (sprob > 0) && ($urandom_range(99) < sprob);
    endfunction

    // One complete run: gaps[i] = LOAD cycles before byte i (gaps[0] >= 1).
    task automatic add_run(input int n, input logic [7:0] data [8], input int gaps [8],
                           input int hmode, input int sprob);
        int         shifts;
        logic       rdy, bv, bit_e;
        logic [7:0] bin;
        shifts = 0;
        push(1'b0, 1'b1, 8'(n), rb(), r8(), hb(hmode), 0, 0, 0, 0, 0, 1, 1);
        if (n > 0) begin
            for (int g = 0; g < gaps[0]; g++)
                push(1'b0, sb(sprob), r8(), (g == gaps[0] - 1), data[0], hb(hmode),
                     1, 1, 0, 0, 0, 1, 0);
        end
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                rdy   = (b == 7) && (i < n - 1);
                bit_e = data[i][7 - b];
                if (rdy && gaps[i + 1] == 0) begin
                    bv = 1'b1; bin = data[i + 1];
                end else if (rdy) begin
                    bv = 1'b0; bin = r8();
                end else begin
                    bv = rb(); bin = r8();
                end
                push(1'b0, sb(sprob), r8(), bv, bin,
                     (hmode == 2) ? (shifts < 6) : hb(hmode), 1, rdy, bit_e, 1, 0, 1, 0);
                shifts++;
            end
            if (i < n - 1 && gaps[i + 1] > 0) begin
                for (int g = 0; g < gaps[i + 1]; g++)
                    push(1'b0, sb(sprob), r8(), (g == gaps[i + 1] - 1), data[i + 1], hb(hmode),
                         1, 1, 0, 0, 0, 1, 0);
            end
        end
        for (int d = 0; d < DRAIN_CYC; d++)
            push(1'b0, sb(sprob), r8(), rb(), r8(), hb(hmode), 1, 0, 0, 0, 0, 1, 0);
        push(1'b0, 1'b0, r8(), rb(), r8(), hb(hmode), 0, 0, 0, 0, 1, 1, 0);
        push(1'b0, 1'b0, r8(), rb(), r8(), hb(hmode), 0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic apply(input vec_t v);
        logic [21:0] got, exp;
        got = {busy, byte_ready, ser_out, ser_valid, done, overflow, hit_cnt,
               s_busy, s_ready, s_so, s_sv, s_done, s_ovf, s_cnt};
        exp = {v.eb, v.er, v.eso, v.esv, v.ed, v.eovf8, v.ecnt8,
               v.eb, v.er, v.eso, v.esv, v.ed, v.eovf2, v.ecnt2};
        if (v.chk) begin
            n_vec++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL vec[%0d] {busy,rdy,so,sv,done,ovf,cnt8 | sat...,ovf2,cnt2} got=%b exp=%b",
                         vidx, got, exp);
            end
        end
        Reset = v.rst; start = v.st; num_bytes = v.nb;
        byte_valid = v.bv; byte_in = v.bin; det_vec = v.hit;
        vidx++;
        step();
    endtask

    task automatic run_queue();
        foreach (q[i]) apply(q[i]);
        q.delete();
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d exp %0d", name, got, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  d [8];
        int          g [8];
        logic [7:0]  bytes3 [3];
        logic [23:0] bits;
        logic [7:0]  pat;
        int          k, nbits, first_sv, last_sv, done_cyc, cnt_at_done, seen;
        logic        gap, xfer;

        // Reset table: two reset cycles, start/byte_valid asserted during reset.
        rtab[0] = mkv(1, 0, 8'd0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        rtab[1] = mkv(1, 1, 8'd5, 1, 8'hFF, 1, 0, 0, 0, 0, 0, 1);
        rtab[2] = mkv(0, 0, 8'd0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 1);
        rtab[3] = mkv(0, 0, 8'd0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 1);

        Reset = 1'b1; start = 1'b0; num_bytes = '0; byte_in = '0;
        byte_valid = 1'b0; det_vec = 1'b0; det_sel = 1'b0;
        @(negedge Clk);
        for (int i = 0; i < 4; i++) apply(rtab[i]);

        // Back-to-back run through the live 0x45 detector.
        bytes3[0] = 8'h26; bytes3[1] = 8'h45; bytes3[2] = 8'h93;
        det_sel = 1'b1; k = 0; nbits = 0; bits = '0; first_sv = -1; last_sv = -1;
        gap = 1'b0; done_cyc = -1; cnt_at_done = -1;
        for (int cyc = 0; cyc < 100 && done_cyc < 0; cyc++) begin
            if (ser_valid) begin
                if (last_sv >= 0 && last_sv != cyc - 1) gap = 1'b1;
                if (first_sv < 0) first_sv = cyc;
                last_sv = cyc;
                bits = {bits[22:0], ser_out};
                nbits++;
            end
            if (done) begin
                done_cyc = cyc;
                cnt_at_done = int'(hit_cnt);
            end
            start = (cyc == 0); num_bytes = 8'd3;
            byte_valid = (k < 3);
            byte_in = (k < 3) ? bytes3[k] : 8'h00;
            xfer = byte_valid && byte_ready;
            @(posedge Clk);
            if (xfer) k++;
            @(negedge Clk);
        end
        start = 1'b0; byte_valid = 1'b0; det_sel = 1'b0;
        check("b2b_done_seen", int'(done_cyc >= 0), 1);
        check("b2b_first_bit_cycle", first_sv, 2);
        check("b2b_bit_count", nbits, 24);
        check("b2b_bits", int'(bits), 32'h264593);
        check("b2b_no_gap", int'(gap), 0);
        check("b2b_done_latency", done_cyc - last_sv, DRAIN_CYC + 1);
        check("b2b_hit_cnt", cnt_at_done, 1);

        // Model-driven runs: stall, empty, saturation.
        push(1'b1, 1'b0, 8'd0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        d[0] = 8'h26; d[1] = 8'h45; d[2] = 8'h93;
        for (int i = 3; i < 8; i++) d[i] = r8();
        g[0] = 1; g[1] = 5; g[2] = 0;
        for (int i = 3; i < 8; i++) g[i] = 0;
        add_run(3, d, g, 1, 0);
        add_run(0, d, g, 1, 0);
        g[0] = 2; g[1] = 0;
        add_run(2, d, g, 2, 0);
        run_queue();
        check("sat_cnt2", int'(s_cnt), 3);
        check("sat_ovf2", int'(s_ovf), 1);
        check("sat_cnt8", int'(hit_cnt), 6);

        // Start held high through a whole run must not disturb it.
        g[0] = 1; g[1] = 2;
        add_run(2, d, g, 1, 100);
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 8; i++) begin
                d[i] = r8();
                g[i] = ($urandom_range(3) == 0) ? $urandom_range(6) : $urandom_range(1);
            end
            g[0] = $urandom_range(3, 1);
            add_run($urandom_range(6), d, g, 1, 15);
        end
        run_queue();

        // Reset during the second byte: no done, everything cleared.
        pat = 8'hA5;
        start = 1'b1; num_bytes = 8'd3; byte_valid = 1'b1; byte_in = pat; det_vec = 1'b1;
        step();
        start = 1'b0;
        repeat (13) step();
        check("abort_pre_sv", int'(ser_valid), 1);
        check("abort_pre_so", int'(ser_out), int'(pat[3]));
        check("abort_pre_cnt", int'(hit_cnt), 13);
        Reset = 1'b1;
        step();
        Reset = 1'b0; byte_valid = 1'b0; det_vec = 1'b0;
        check("abort_idle", int'({busy, byte_ready, ser_valid, ser_out, done}), 0);
        check("abort_cnt_clr", int'(hit_cnt), 0);
        seen = 0;
        for (int i = 0; i < 3 * DRAIN_CYC + 4; i++) begin
            if (done || busy) seen = 1;
            step();
        end
        check("abort_no_done", seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
